// File: rtl/as5600_i2c_target.sv
`timescale 1ns/1ps
// AS5600 register-read emulator on an oversampled I2C target port.
// Serves a 12-bit angle from a shadow register and drives SDA open-drain.
//
// state       | meaning
// ------------+--------------------------------------------------
// IDLE        | bus free or not addressed, SDA released
// ADDR        | shifting in the address byte
// ADDR_ACK    | acknowledging our address
// PTR         | shifting in the register pointer
// PTR_ACK     | acknowledging the pointer byte
// WDATA       | shifting in write data (discarded)
// WDATA_ACK   | acknowledging a write data byte
// TX          | shifting out the byte at reg_ptr
// TX_ACK      | released, sampling the initiator's ACK/NACK
// WAIT        | NACK received, idle until START/STOP
module as5600_i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h36,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] raw_angle,
  input  logic        angle_load,
  output logic [7:0]  reg_ptr,
  output logic        busy,
  output logic        xfer_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_TX, S_TX_ACK, S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_hist, sda_hist;
  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        ack_phase;
  logic        rw;
  logic [11:0] shadow;
  logic [7:0]  latch_lo;
  logic        latch_valid;
  logic [7:0]  tx_byte;
  logic        hi_load;
  logic        tx_load;
  logic        rx_last;
  logic        addr_match;
  logic        sda_oe_nxt;

  // Synchronize both bus lines; reset to the idle-high level so release is not seen as START
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist;
  assign scl_fall   = ~scl_s & scl_hist;
  assign start_det  = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_det   = scl_s & scl_hist & ~sda_hist & sda_s;
  assign rx_last    = (bit_cnt == 3'd0);
  assign addr_match = (shreg[6:0] == DEV_ADDR);
  assign tx_load    = scl_fall & ack_phase &
                      (((state == S_ADDR_ACK) & rw) | (state == S_TX_ACK));

  // Capture the served angle whenever the host pulses angle_load
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) shadow <= 12'h000;
    else if (angle_load) shadow <= raw_angle;
  end

  // Register map; the low angle byte comes from the latch taken at the high-byte load
  always_comb begin
    tx_byte = 8'h00;
    hi_load = 1'b0;
    case (reg_ptr)
      8'h0B: tx_byte = 8'h20;
      8'h0C, 8'h0E: begin
        tx_byte = {4'h0, shadow[11:8]};
        hi_load = 1'b1;
      end
      8'h0D, 8'h0F: tx_byte = latch_valid ? latch_lo : shadow[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  end

  // FSM next-state; STOP and START override every state
  always_comb begin
    state_nxt = state;
    if (stop_det) state_nxt = S_IDLE;
    else if (start_det) state_nxt = S_ADDR;
    else begin
      case (state)
        S_ADDR:      if (scl_rise && rx_last) state_nxt = addr_match ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK:  if (scl_fall && ack_phase) state_nxt = rw ? S_TX : S_PTR;
        S_PTR:       if (scl_rise && rx_last) state_nxt = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall && ack_phase) state_nxt = S_WDATA;
        S_WDATA:     if (scl_rise && rx_last) state_nxt = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall && ack_phase) state_nxt = S_WDATA;
        S_TX:        if (scl_rise && rx_last) state_nxt = S_TX_ACK;
        S_TX_ACK: begin
          if (scl_rise && sda_s) state_nxt = S_WAIT;
          else if (scl_fall && ack_phase) state_nxt = S_TX;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // FSM output: next SDA drive, only moved on synced SCL fall (or released on START/STOP)
  always_comb begin
    sda_oe_nxt = sda_oe;
    if (stop_det || start_det) sda_oe_nxt = 1'b0;
    else if (scl_fall) begin
      case (state)
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: sda_oe_nxt = ~ack_phase;
        S_TX:                               sda_oe_nxt = ~shreg[6];
        default:                            sda_oe_nxt = 1'b0;
      endcase
      if (tx_load) sda_oe_nxt = ~tx_byte[7];
    end
  end

  // Registered SDA drive so reset releases the line immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sda_oe <= 1'b0;
    else sda_oe <= sda_oe_nxt;
  end

  // Datapath: bit down-counter, shifter, pointer, coherency latch, busy/done flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= 3'd7;
      shreg       <= 8'h00;
      ack_phase   <= 1'b0;
      rw          <= 1'b0;
      reg_ptr     <= 8'h00;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
      latch_lo    <= 8'h00;
      latch_valid <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      if (stop_det) begin
        busy      <= 1'b0;
        xfer_done <= busy;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        bit_cnt   <= 3'd7;
        ack_phase <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt - 3'd1;
            if (rx_last && state == S_ADDR) begin
              rw <= sda_s;
              if (addr_match) busy <= 1'b1;
            end
            if (rx_last && state == S_PTR) reg_ptr <= {shreg[6:0], sda_s};
          end
          S_TX: bit_cnt <= bit_cnt - 3'd1;
          // Pointer advances after every transmitted byte, the final NACKed one included
          S_TX_ACK: begin
            ack_phase <= 1'b1;
            reg_ptr   <= reg_ptr + 8'd1;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            ack_phase <= ~ack_phase;
            bit_cnt   <= 3'd7;
          end
          S_TX:     shreg <= {shreg[6:0], 1'b0};
          S_TX_ACK: if (ack_phase) ack_phase <= 1'b0;
          default: ;
        endcase
        if (tx_load) begin
          shreg       <= tx_byte;
          bit_cnt     <= 3'd7;
          latch_valid <= hi_load;
          if (hi_load) latch_lo <= shadow[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_as5600_i2c_target.sv
`timescale 1ns/1ps
// Scoreboard bench for as5600_i2c_target: an I2C initiator model drives
// directed transactions, pushes expected ACK/data bytes, and a monitor
// compares each byte the bus returns.
module tb_as5600_i2c_target;

  localparam int Q = 50;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [11:0] raw_angle = 12'h000;
  logic        angle_load = 1'b0;
  logic [7:0]  reg_ptr;
  logic        busy;
  logic        xfer_done;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clock = ~clock;

  as5600_i2c_target #(.DEV_ADDR(7'h36), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .scl        (scl),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .raw_angle  (raw_angle),
    .angle_load (angle_load),
    .reg_ptr    (reg_ptr),
    .busy       (busy),
    .xfer_done  (xfer_done)
  );

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  event       obs_ev;
  int         n_checks = 0;
  int         n_errors = 0;
  int         xd_cnt = 0;
  int         oe_cnt = 0;

  // count clocks with xfer_done high and with SDA driven
  always @(posedge clock) if (xfer_done) xd_cnt <= xd_cnt + 1;
  always @(posedge clock) if (sda_oe) oe_cnt <= oe_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic [7:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    exp_q.push_back(e);
  endtask

  task automatic put_obs(input logic [7:0] v);
    obs_q.push_back(v);
    ->obs_ev;
  endtask

  // monitor: pairs every observed bus byte with the oldest expectation
  initial begin : monitor
    logic [7:0] o;
    exp_t       e;
    forever begin
      @(obs_ev);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %0h expected nothing", o);
        end else begin
          e = exp_q.pop_front();
          chk(e.nm, 32'(o), 32'(e.v));
        end
      end
    end
  end

  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    #Q scl = 1'b1;
    #Q r = sda_in;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic wr(input logic [7:0] b, input logic exp_nack, input string nm);
    logic r;
    push_exp(nm, {7'd0, exp_nack});
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    put_obs({7'd0, r});
  endtask

  task automatic rd(input logic [7:0] exp_b, input logic nack, input string nm);
    logic       r;
    logic [7:0] d;
    push_exp(nm, exp_b);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, r);
      d = {d[6:0], r};
    end
    bit_io(nack, r);
    put_obs(d);
  endtask

  task automatic load(input logic [11:0] v);
    raw_angle  = v;
    angle_load = 1'b1;
    #10 angle_load = 1'b0;
  endtask

  task automatic summary;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
  endtask

  initial begin : watchdog
    #3_000_000;
    n_errors++;
    $display("FAIL watchdog: run still active at %0t, limit 3ms", $time);
    summary();
    $fatal(1, "timeout");
  end

  initial begin : stim
    int xd0;
    int oe0;
    logic r;

    repeat (5) @(posedge clock);
    #2 reset_n = 1'b1;
    #50;
    chk("reset_sda_oe", 32'(sda_oe), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_reg_ptr", 32'(reg_ptr), 32'h00);
    chk("reset_xfer_done", 32'(xfer_done), 32'd0);

    // basic read with repeated start
    load(12'hA5C);
    xd0 = xd_cnt;
    i2c_start();
    wr(8'h6C, 1'b0, "t2_addr_w_ack");
    wr(8'h0C, 1'b0, "t2_ptr_ack");
    i2c_start();
    wr(8'h6D, 1'b0, "t2_addr_r_ack");
    chk("t2_busy_mid", 32'(busy), 32'd1);
    rd(8'h0A, 1'b0, "t2_hi");
    rd(8'h5C, 1'b1, "t2_lo");
    i2c_stop();
    #100;
    chk("t2_reg_ptr", 32'(reg_ptr), 32'h0E);
    chk("t2_xfer_done_cycles", 32'(xd_cnt - xd0), 32'd1);
    chk("t2_busy_after", 32'(busy), 32'd0);

    // coherent read: new angle arrives while the high byte is on the wire
    load(12'h123);
    i2c_start();
    wr(8'h6C, 1'b0, "t3_addr_w_ack");
    wr(8'h0C, 1'b0, "t3_ptr_ack");
    i2c_start();
    wr(8'h6D, 1'b0, "t3_addr_r_ack");
    fork
      rd(8'h01, 1'b0, "t3_hi");
      begin
        #(6*Q);
        load(12'hFFF);
      end
    join
    rd(8'h23, 1'b1, "t3_lo_latched");
    i2c_stop();
    i2c_start();
    wr(8'h6C, 1'b0, "t3b_addr_w_ack");
    wr(8'h0C, 1'b0, "t3b_ptr_ack");
    i2c_start();
    wr(8'h6D, 1'b0, "t3b_addr_r_ack");
    rd(8'h0F, 1'b0, "t3b_hi");
    rd(8'hFF, 1'b1, "t3b_lo");
    i2c_stop();

    // address mismatch
    #100;
    xd0 = xd_cnt;
    oe0 = oe_cnt;
    i2c_start();
    wr(8'h70, 1'b1, "t4_addr_nack");
    i2c_stop();
    #100;
    chk("t4_sda_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_xfer_done_cycles", 32'(xd_cnt - xd0), 32'd0);

    // pointer wrap and STATUS
    i2c_start();
    wr(8'h6C, 1'b0, "t5_addr_w_ack");
    wr(8'hFF, 1'b0, "t5_ptr_ack");
    i2c_start();
    wr(8'h6D, 1'b0, "t5_addr_r_ack");
    rd(8'h00, 1'b0, "t5_rd_ff");
    rd(8'h00, 1'b0, "t5_rd_00");
    rd(8'h00, 1'b1, "t5_rd_01");
    i2c_stop();
    #100;
    chk("t5_reg_ptr_wrap", 32'(reg_ptr), 32'h02);
    i2c_start();
    wr(8'h6C, 1'b0, "t5s_addr_w_ack");
    wr(8'h0B, 1'b0, "t5s_ptr_ack");
    i2c_start();
    wr(8'h6D, 1'b0, "t5s_addr_r_ack");
    rd(8'h20, 1'b1, "t5s_status");
    i2c_stop();
    #100;
    chk("t5s_reg_ptr", 32'(reg_ptr), 32'h0C);

    // abort A: START after 4 bits of a write data byte
    xd0 = xd_cnt;
    i2c_start();
    wr(8'h6C, 1'b0, "tA_addr_w_ack");
    wr(8'h0B, 1'b0, "tA_ptr_ack");
    bit_io(1'b1, r);
    bit_io(1'b0, r);
    bit_io(1'b1, r);
    bit_io(1'b0, r);
    i2c_start();
    wr(8'h6D, 1'b0, "tA_addr_r_ack");
    rd(8'h20, 1'b0, "tA_status");
    rd(8'h0F, 1'b0, "tA_hi");
    rd(8'hFF, 1'b1, "tA_lo");
    i2c_stop();
    #100;
    chk("tA_reg_ptr", 32'(reg_ptr), 32'h0E);
    chk("tA_xfer_done_cycles", 32'(xd_cnt - xd0), 32'd1);

    // abort B: reset while the target drives a 0 bit
    i2c_start();
    wr(8'h6C, 1'b0, "tB_addr_w_ack");
    wr(8'h0C, 1'b0, "tB_ptr_ack");
    i2c_start();
    wr(8'h6D, 1'b0, "tB_addr_r_ack");
    chk("tB_sda_driving", 32'(sda_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("tB_sda_async_release", 32'(sda_oe), 32'd0);
    #9;
    scl   = 1'b1;
    sda_m = 1'b1;
    #100 reset_n = 1'b1;
    #100;
    chk("tB_reg_ptr_reset", 32'(reg_ptr), 32'h00);
    chk("tB_busy_reset", 32'(busy), 32'd0);
    xd0 = xd_cnt;
    i2c_start();
    wr(8'h6C, 1'b0, "tB2_addr_w_ack");
    wr(8'h0B, 1'b0, "tB2_ptr_ack");
    i2c_start();
    wr(8'h6D, 1'b0, "tB2_addr_r_ack");
    rd(8'h20, 1'b1, "tB2_status");
    i2c_stop();
    #100;
    chk("tB2_xfer_done_cycles", 32'(xd_cnt - xd0), 32'd1);

    for (int i = 0; i < 1000 && obs_q.size() > 0; i++) @(posedge clock);
    chk("scoreboard_pending", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
